// File: rtl/core_control_scoreboard_pkg.sv
// Shared core micro-architecture definitions for the control scoreboard:
// register-number type, resource indices and the counter-width default.
package core_control_scoreboard_pkg;

  localparam int CNT_W_DEFAULT = 2;
  localparam int NUM_GPR       = 16;
  localparam int PC_REG        = 15;
  localparam int FLAGS_IDX     = 16;
  localparam int NUM_RES       = 17;

  typedef logic [3:0] reg_num_t;
  typedef logic [4:0] res_idx_t;

  // Map a GPR number onto the 17-entry resource index space.
  function automatic res_idx_t gpr_res(input reg_num_t r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/core_control_scoreboard_cnt.sv
// One in-flight write counter of the control scoreboard. Saturates at its
// maximum, holds at zero on a stray retirement and reports that as underflow.
// Flush clears the count and masks the underflow report.
module core_control_scoreboard_cnt
  import core_control_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: flush wins, simultaneous inc/dec cancel, clamp at both ends.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else if (inc && !dec) begin
      if (count_r != CNT_MAX) begin
        count_nxt_s = count_r + CNT_ONE;
      end else begin
        count_nxt_s = count_r;
      end
    end else if (dec && !inc) begin
      if (count_r != CNT_ZERO) begin
        count_nxt_s = count_r - CNT_ONE;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Counter register; reset discards all tracking immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign sat       = (count_r == CNT_MAX);
  assign underflow = dec && !flush && (count_r == CNT_ZERO);

endmodule

// File: rtl/core_control_scoreboard.sv
// Control scoreboard: tracks in-flight GPR and flags writes with 17 small
// counters and raises per-source hazards, full and a bubble request.
// Optional feature macro: CORE_SCOREBOARD_FWD_EN -- when defined, a source
// whose only pending write retires this cycle is not reported as a hazard,
// since writeback forwarding supplies the value.
module core_control_scoreboard
  import core_control_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     issue_valid,
  input  logic     issue_wb,
  input  reg_num_t issue_rd,
  input  logic     issue_flags,
  input  logic     wb_valid,
  input  reg_num_t wb_rd,
  input  logic     wb_flags,
  input  logic     q_rn_valid,
  input  logic     q_rm_valid,
  input  logic     q_rs_valid,
  input  reg_num_t q_rn,
  input  reg_num_t q_rm,
  input  reg_num_t q_rs,
  input  logic     q_flags,
  input  logic     flush,
  output logic     rn_hazard,
  output logic     rm_hazard,
  output logic     rs_hazard,
  output logic     flags_hazard,
  output logic     pc_hazard,
  output logic     next_bubble,
  output logic     full,
  output logic     busy,
  output logic     underflow_err
);

`ifdef CORE_SCOREBOARD_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]   count_s [NUM_RES];
  logic [NUM_RES-1:0] sat_s;
  logic [NUM_RES-1:0] inc_s;
  logic [NUM_RES-1:0] dec_s;
  logic [NUM_RES-1:0] uf_s;
  logic [NUM_RES-1:0] nz_s;
  logic               issue_accept_s;
  logic               full_s;
  logic               rn_hz_s;
  logic               rm_hz_s;
  logic               rs_hz_s;
  logic               flags_hz_s;
  logic               pc_hz_s;
  logic               bubble_s;
  logic               underflow_err_r;

  // A source is blocked while it has pending writes, unless forwarding covers
  // the last pending write retiring in this very cycle.
  function automatic logic src_hazard(input logic qv,
                                      input logic [CNT_W-1:0] cnt,
                                      input logic retire);
    logic fwd_hit;
    fwd_hit = FWD_EN && retire && (cnt == CNT_ONE);
    return qv && (cnt != CNT_ZERO) && !fwd_hit;
  endfunction

  // Retirement decode; independent of issue so full can look at it safely.
  always_comb begin
    dec_s = {NUM_RES{1'b0}};
    for (int i = 0; i < NUM_GPR; i++) begin
      dec_s[i] = wb_valid && (wb_rd == reg_num_t'(i));
    end
    dec_s[FLAGS_IDX] = wb_flags;
  end

  // Full: a targeted counter is saturated and nothing drains it this cycle.
  always_comb begin
    full_s = 1'b0;
    if (issue_valid) begin
      full_s = (issue_wb && sat_s[gpr_res(issue_rd)] && !dec_s[gpr_res(issue_rd)]) ||
               (issue_flags && sat_s[FLAGS_IDX] && !dec_s[FLAGS_IDX]);
    end else begin
      full_s = 1'b0;
    end
  end

  // Source hazards, the PC hazard and the combined bubble request.
  always_comb begin
    rn_hz_s    = src_hazard(q_rn_valid, count_s[gpr_res(q_rn)], dec_s[gpr_res(q_rn)]);
    rm_hz_s    = src_hazard(q_rm_valid, count_s[gpr_res(q_rm)], dec_s[gpr_res(q_rm)]);
    rs_hz_s    = src_hazard(q_rs_valid, count_s[gpr_res(q_rs)], dec_s[gpr_res(q_rs)]);
    flags_hz_s = src_hazard(q_flags, count_s[FLAGS_IDX], dec_s[FLAGS_IDX]);
    pc_hz_s    = issue_valid && nz_s[PC_REG];
    bubble_s   = rn_hz_s || rm_hz_s || rs_hz_s || flags_hz_s || pc_hz_s || full_s;
    issue_accept_s = issue_valid && !bubble_s;
  end

  // Issue decode: only an accepted instruction allocates tracking.
  always_comb begin
    inc_s = {NUM_RES{1'b0}};
    for (int i = 0; i < NUM_GPR; i++) begin
      inc_s[i] = issue_accept_s && issue_wb && (issue_rd == reg_num_t'(i));
    end
    inc_s[FLAGS_IDX] = issue_accept_s && issue_flags;
  end

  for (genvar g = 0; g < NUM_RES; g++) begin : g_cnt
    core_control_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_s[g]),
      .dec       (dec_s[g]),
      .flush     (flush),
      .count     (count_s[g]),
      .sat       (sat_s[g]),
      .underflow (uf_s[g])
    );
    assign nz_s[g] = (count_s[g] != CNT_ZERO);
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err_r <= 1'b0;
    end else if (|uf_s) begin
      underflow_err_r <= 1'b1;
    end else begin
      underflow_err_r <= underflow_err_r;
    end
  end

  assign rn_hazard     = rn_hz_s;
  assign rm_hazard     = rm_hz_s;
  assign rs_hazard     = rs_hz_s;
  assign flags_hazard  = flags_hz_s;
  assign pc_hazard     = pc_hz_s;
  assign next_bubble   = bubble_s;
  assign full          = full_s;
  assign busy          = |nz_s;
  assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_core_control_scoreboard.sv
// Scoreboard-style bench for core_control_scoreboard (CNT_W = 2). Stimulus
// pushes hand-computed output vectors; a negedge monitor pops and compares.
// Honours CORE_SCOREBOARD_FWD_EN for the forwarding-dependent vectors.
module tb_core_control_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_wb, issue_flags;
  logic [3:0] issue_rd;
  logic       wb_valid, wb_flags;
  logic [3:0] wb_rd;
  logic       q_rn_valid, q_rm_valid, q_rs_valid, q_flags;
  logic [3:0] q_rn, q_rm, q_rs;
  logic       flush;
  logic       rn_hazard, rm_hazard, rs_hazard, flags_hazard, pc_hazard;
  logic       next_bubble, full, busy, underflow_err;
  logic [8:0] out_s;

  localparam logic [8:0] RN  = 9'b100000000;
  localparam logic [8:0] RM  = 9'b010000000;
  localparam logic [8:0] RS  = 9'b001000000;
  localparam logic [8:0] FLG = 9'b000100000;
  localparam logic [8:0] PC  = 9'b000010000;
  localparam logic [8:0] NB  = 9'b000001000;
  localparam logic [8:0] FUL = 9'b000000100;
  localparam logic [8:0] BSY = 9'b000000010;
  localparam logic [8:0] UF  = 9'b000000001;
  localparam logic [8:0] NONE = 9'b000000000;

  typedef struct {
    string      name;
    logic [8:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  core_control_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rd(issue_rd),
    .issue_flags(issue_flags),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_flags(wb_flags),
    .q_rn_valid(q_rn_valid), .q_rm_valid(q_rm_valid), .q_rs_valid(q_rs_valid),
    .q_rn(q_rn), .q_rm(q_rm), .q_rs(q_rs), .q_flags(q_flags),
    .flush(flush),
    .rn_hazard(rn_hazard), .rm_hazard(rm_hazard), .rs_hazard(rs_hazard),
    .flags_hazard(flags_hazard), .pc_hazard(pc_hazard),
    .next_bubble(next_bubble), .full(full), .busy(busy),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  assign out_s = {rn_hazard, rm_hazard, rs_hazard, flags_hazard, pc_hazard,
                  next_bubble, full, busy, underflow_err};

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (out_s !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b (rn rm rs flg pc nb full busy uf)",
                 e.name, out_s, e.val);
      end
    end
  end

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_wb = 1'b0; issue_rd = 4'd0; issue_flags = 1'b0;
    wb_valid = 1'b0; wb_rd = 4'd0; wb_flags = 1'b0;
    q_rn_valid = 1'b0; q_rm_valid = 1'b0; q_rs_valid = 1'b0; q_flags = 1'b0;
    q_rn = 4'd0; q_rm = 4'd0; q_rs = 4'd0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic chk(input string n, input logic [8:0] v);
    exp_q.push_back('{name: n, val: v});
  endtask

  task automatic issue_gpr(input logic [3:0] rd);
    issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = rd;
  endtask

  task automatic retire_gpr(input logic [3:0] rd);
    wb_valid = 1'b1; wb_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    q_rn_valid = 1'b1; q_rn = 4'd3; issue_valid = 1'b1;
    chk("reset_idle", NONE);
    step(); rst_n = 1'b1;

    // RAW hazard on r3 and its clearing by writeback.
    step(); issue_gpr(4'd3); q_rn_valid = 1'b1; q_rn = 4'd3;
    chk("r3_issue_no_self_hazard", NONE);
    step(); issue_gpr(4'd4); q_rn_valid = 1'b1; q_rn = 4'd3;
    chk("r3_rn_hazard", RN | NB | BSY);
    step(); retire_gpr(4'd3); q_rn_valid = 1'b1; q_rn = 4'd3; q_rm_valid = 1'b1; q_rm = 4'd4;
`ifdef CORE_SCOREBOARD_FWD_EN
    chk("r3_wb_same_cycle_fwd", BSY);
`else
    chk("r3_wb_same_cycle_nofwd", RN | NB | BSY);
`endif
    step(); q_rn_valid = 1'b1; q_rn = 4'd3;
    chk("r3_cleared", NONE);

    // Saturation of r5 at 3 and full behaviour.
    step(); issue_gpr(4'd5); chk("r5_issue1", NONE);
    step(); issue_gpr(4'd5); chk("r5_issue2", BSY);
    step(); issue_gpr(4'd5); chk("r5_issue3", BSY);
    step(); issue_gpr(4'd5); chk("r5_full", FUL | NB | BSY);
    step(); issue_gpr(4'd5); chk("r5_full_held", FUL | NB | BSY);
    step(); issue_gpr(4'd5); retire_gpr(4'd5); chk("r5_full_released_by_wb", BSY);
    step(); issue_gpr(4'd5); q_rs_valid = 1'b1; q_rs = 4'd5;
    chk("r5_still_three", RS | FUL | NB | BSY);
    step(); retire_gpr(4'd5); chk("r5_drain1", BSY);
    step(); retire_gpr(4'd5);
    step(); retire_gpr(4'd5);
    step(); q_rs_valid = 1'b1; q_rs = 4'd5; chk("r5_drained", NONE);

    // Same-cycle issue and retirement of r7 leaves the count at 1.
    step(); issue_gpr(4'd7); chk("r7_issue", NONE);
    step(); issue_gpr(4'd7); retire_gpr(4'd7); chk("r7_inc_dec", BSY);
    step(); q_rm_valid = 1'b1; q_rm = 4'd7; chk("r7_still_one", RM | NB | BSY);
    step(); retire_gpr(4'd7); chk("r7_retire", BSY);
    step(); q_rm_valid = 1'b1; q_rm = 4'd7; chk("r7_empty", NONE);

    // Underflow on r9 is sticky.
    step(); retire_gpr(4'd9); chk("r9_underflow_pending", NONE);
    step(); chk("r9_underflow_set", UF);
    step(); issue_gpr(4'd2); chk("uf_sticky_issue", UF);
    step(); chk("uf_sticky_busy", UF | BSY);
    step(); retire_gpr(4'd2); chk("uf_sticky_retire", UF | BSY);
    step(); chk("uf_sticky_idle", UF);

    // PC hazard and flush.
    step(); issue_gpr(4'd15); chk("pc_issue", UF);
    step(); issue_valid = 1'b1; chk("pc_hazard", PC | NB | BSY | UF);
    step(); issue_valid = 1'b1; flush = 1'b1; chk("flush_cycle", PC | NB | BSY | UF);
    step(); issue_valid = 1'b1; chk("after_flush", UF);

    // Flags hazard, then reset mid-flight.
    step(); issue_gpr(4'd6); issue_flags = 1'b1; chk("flags_issue", UF);
    step(); q_flags = 1'b1; q_rs_valid = 1'b1; q_rs = 4'd6;
    chk("flags_hazard", RS | FLG | NB | BSY | UF);
    step(); q_flags = 1'b1; q_rs_valid = 1'b1; q_rs = 4'd6; rst_n = 1'b0;
    chk("reset_mid_flight", NONE);
    step(); rst_n = 1'b1; q_flags = 1'b1; q_rs_valid = 1'b1; q_rs = 4'd6;
    chk("after_reset", NONE);

    // A flush cycle does not record an underflow.
    step(); issue_gpr(4'd1); chk("flush_uf_issue", NONE);
    step(); flush = 1'b1; retire_gpr(4'd9); chk("flush_with_stray_wb", BSY);
    step(); chk("flush_no_underflow", NONE);

    // Flags retirement in the same cycle as the query.
    step(); issue_valid = 1'b1; issue_flags = 1'b1; chk("flags_issue2", NONE);
    step(); q_flags = 1'b1; wb_flags = 1'b1;
`ifdef CORE_SCOREBOARD_FWD_EN
    chk("flags_wb_same_cycle_fwd", BSY);
`else
    chk("flags_wb_same_cycle_nofwd", FLG | NB | BSY);
`endif
    step(); q_flags = 1'b1; chk("flags_cleared", NONE);

    step();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
